// File: rtl/pipeline_controller.sv
// Hazard/sequencing controller for the IF-ID | EX | MEM-WB pipeline: fetch PC, stall/squash, forwarding selects, halt drain.
// Build option: define PIPE_FORWARDING_EN to enable operand forwarding; otherwise every RAW hazard stalls.
module pipeline_controller #(
    parameter int PC_W         = 5,
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] fd_rs1,
    input  logic [REG_W-1:0] fd_rs2,
    input  logic             fd_uses_rs1,
    input  logic             fd_uses_rs2,
    input  logic             fd_halt,
    input  logic             ex_jump,
    input  logic [PC_W-1:0]  ex_jump_pc,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             ex_reg_wrenable,
    input  logic             ex_mem_to_reg,
    input  logic [REG_W-1:0] mw_write_reg,
    input  logic             mw_reg_wrenable,
    output logic [PC_W-1:0]  pc,
    output logic             fd_hold,
    output logic             ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic             halted_q, halted_d;

    logic hit_ex_rs1, hit_ex_rs2, hit_mw_rs1, hit_mw_rs2;
    logic stall;
    logic [1:0] sel_a, sel_b;

    assign hit_ex_rs1 = fd_uses_rs1 & ex_reg_wrenable & (ex_write_reg == fd_rs1) & (fd_rs1 != '0);
    assign hit_ex_rs2 = fd_uses_rs2 & ex_reg_wrenable & (ex_write_reg == fd_rs2) & (fd_rs2 != '0);
    assign hit_mw_rs1 = fd_uses_rs1 & mw_reg_wrenable & (mw_write_reg == fd_rs1) & (fd_rs1 != '0);
    assign hit_mw_rs2 = fd_uses_rs2 & mw_reg_wrenable & (mw_write_reg == fd_rs2) & (fd_rs2 != '0);

`ifdef PIPE_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; ALU results are bypassed.
    assign stall = ex_mem_to_reg & (hit_ex_rs1 | hit_ex_rs2);
    assign sel_a = hit_ex_rs1 ? 2'b01 : (hit_mw_rs1 ? 2'b10 : 2'b00);
    assign sel_b = hit_ex_rs2 ? 2'b01 : (hit_mw_rs2 ? 2'b10 : 2'b00);
`else
    // Without bypass paths the consumer waits until no in-flight producer matches.
    logic unused_mem_to_reg;
    assign unused_mem_to_reg = ex_mem_to_reg;
    assign stall = hit_ex_rs1 | hit_ex_rs2 | hit_mw_rs1 | hit_mw_rs2;
    assign sel_a = 2'b00;
    assign sel_b = 2'b00;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        fwd_a_d   = 2'b00;
        fwd_b_d   = 2'b00;
        fd_hold   = 1'b0;
        ex_bubble = 1'b0;
        case (state_q)
            S_RUN: begin
                if (ex_jump) begin
                    pc_d      = ex_jump_pc;
                    ex_bubble = 1'b1;
                end else if (stall) begin
                    fd_hold   = 1'b1;
                    ex_bubble = 1'b1;
                end else if (fd_halt) begin
                    fd_hold   = 1'b1;
                    ex_bubble = 1'b1;
                    cnt_d     = CNT_W'(DRAIN_CYCLES);
                    state_d   = S_DRAIN;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    fwd_a_d = sel_a;
                    fwd_b_d = sel_b;
                end
            end
            S_DRAIN: begin
                fd_hold   = 1'b1;
                ex_bubble = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                end
            end
            S_HALTED: begin
                fd_hold   = 1'b1;
                ex_bubble = 1'b1;
            end
            default: state_d = S_RUN;
        endcase
        // While reset is held, IF-ID keeps flowing but EX sees only NOPs.
        if (reset) begin
            fd_hold   = 1'b0;
            ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            pc_q     <= '0;
            cnt_q    <= '0;
            fwd_a_q  <= 2'b00;
            fwd_b_q  <= 2'b00;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
            halted_q <= halted_d;
        end
    end

    assign pc        = pc_q;
    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign halted    = halted_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller; covers both PIPE_FORWARDING_EN builds.
module tb_pipeline_controller;

    localparam int PC_W  = 5;
    localparam int REG_W = 5;
    localparam logic [1:0] ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALTED = 2'd2;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] fd_rs1, fd_rs2, ex_write_reg, mw_write_reg;
    logic             fd_uses_rs1, fd_uses_rs2, fd_halt, ex_jump;
    logic [PC_W-1:0]  ex_jump_pc;
    logic             ex_reg_wrenable, ex_mem_to_reg, mw_reg_wrenable;
    logic [PC_W-1:0]  pc;
    logic             fd_hold, ex_bubble, halted;
    logic [1:0]       fwd_a, fwd_b, dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] exp_pc;

    pipeline_controller #(.PC_W(PC_W), .REG_W(REG_W), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
        .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
        .fd_halt(fd_halt), .ex_jump(ex_jump), .ex_jump_pc(ex_jump_pc),
        .ex_write_reg(ex_write_reg), .ex_reg_wrenable(ex_reg_wrenable), .ex_mem_to_reg(ex_mem_to_reg),
        .mw_write_reg(mw_write_reg), .mw_reg_wrenable(mw_reg_wrenable),
        .pc(pc), .fd_hold(fd_hold), .ex_bubble(ex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // driver tasks
    task automatic idle();
        fd_rs1 = '0; fd_rs2 = '0; fd_uses_rs1 = 1'b0; fd_uses_rs2 = 1'b0;
        fd_halt = 1'b0; ex_jump = 1'b0; ex_jump_pc = '0;
        ex_write_reg = '0; ex_reg_wrenable = 1'b0; ex_mem_to_reg = 1'b0;
        mw_write_reg = '0; mw_reg_wrenable = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        settle();
        check("reset_fd_hold", fd_hold, 0);
        check("reset_ex_bubble", ex_bubble, 1);
        step();
        step();
        check("reset_pc", pc, 0);
        check("reset_halted", halted, 0);
        check("reset_fwd_a", fwd_a, 0);
        check("reset_fwd_b", fwd_b, 0);
        check("reset_state", dbg_state, ST_RUN);
        reset = 1'b0;

        // sequential fetch with wrap: 1..31, 0, 1
        for (int i = 1; i <= 33; i++) exp_q.push_back(PC_W'(i % 32));
        while (exp_q.size() > 0) begin
            settle();
            check("fetch_bubble", ex_bubble, 0);
            check("fetch_hold", fd_hold, 0);
            step();
            check("fetch_pc", pc, exp_q.pop_front());
        end

        // jump beats concurrent load-use and halt
        fd_rs1 = 5; fd_uses_rs1 = 1'b1;
        ex_write_reg = 5; ex_reg_wrenable = 1'b1; ex_mem_to_reg = 1'b1;
        fd_halt = 1'b1; ex_jump = 1'b1; ex_jump_pc = 17;
        settle();
        check("jump_bubble", ex_bubble, 1);
        check("jump_hold", fd_hold, 0);
        step();
        check("jump_pc", pc, 17);
        check("jump_state", dbg_state, ST_RUN);
        check("jump_fwd_a", fwd_a, 0);
        idle();
        step();
        check("post_jump_pc", pc, 18);
        exp_pc = 18;

`ifdef PIPE_FORWARDING_EN
        // forwarding priority: EX over MEM-WB
        fd_rs1 = 3; fd_uses_rs1 = 1'b1;
        ex_write_reg = 3; ex_reg_wrenable = 1'b1;
        mw_write_reg = 3; mw_reg_wrenable = 1'b1;
        settle();
        check("fwd_no_stall", ex_bubble, 0);
        step(); exp_pc++;
        check("fwd_a_ex", fwd_a, 1);
        check("fwd_pc", pc, exp_pc);
        ex_reg_wrenable = 1'b0;
        step(); exp_pc++;
        check("fwd_a_mw", fwd_a, 2);
        fd_rs1 = 0; ex_write_reg = 0; ex_reg_wrenable = 1'b1; mw_write_reg = 0;
        step(); exp_pc++;
        check("fwd_a_r0", fwd_a, 0);
        idle();
        fd_rs2 = 7; fd_uses_rs2 = 1'b1; mw_write_reg = 7; mw_reg_wrenable = 1'b1;
        step(); exp_pc++;
        check("fwd_b_mw", fwd_b, 2);
        check("fwd_a_idle", fwd_a, 0);

        // load-use: one bubble, then forward from MEM-WB
        idle();
        fd_rs1 = 5; fd_uses_rs1 = 1'b1;
        ex_write_reg = 5; ex_reg_wrenable = 1'b1; ex_mem_to_reg = 1'b1;
        settle();
        check("lu_hold", fd_hold, 1);
        check("lu_bubble", ex_bubble, 1);
        step();
        check("lu_pc_held", pc, exp_pc);
        check("lu_fwd_a", fwd_a, 0);
        ex_reg_wrenable = 1'b0; ex_mem_to_reg = 1'b0; ex_write_reg = 0;
        mw_write_reg = 5; mw_reg_wrenable = 1'b1;
        settle();
        check("lu_release_hold", fd_hold, 0);
        check("lu_release_bubble", ex_bubble, 0);
        step(); exp_pc++;
        check("lu_fwd_mw", fwd_a, 2);
        check("lu_pc_adv", pc, exp_pc);
`else
        // no forwarding: ALU producer in EX for r4 stalls twice
        fd_rs1 = 4; fd_uses_rs1 = 1'b1;
        ex_write_reg = 4; ex_reg_wrenable = 1'b1;
        settle();
        check("nf_stall1_hold", fd_hold, 1);
        check("nf_stall1_bubble", ex_bubble, 1);
        step();
        check("nf_stall1_pc", pc, exp_pc);
        check("nf_stall1_fwd", fwd_a, 0);
        ex_reg_wrenable = 1'b0; ex_write_reg = 0;
        mw_write_reg = 4; mw_reg_wrenable = 1'b1;
        settle();
        check("nf_stall2_hold", fd_hold, 1);
        check("nf_stall2_bubble", ex_bubble, 1);
        step();
        check("nf_stall2_pc", pc, exp_pc);
        mw_reg_wrenable = 1'b0;
        settle();
        check("nf_issue_hold", fd_hold, 0);
        check("nf_issue_bubble", ex_bubble, 0);
        step(); exp_pc++;
        check("nf_issue_pc", pc, exp_pc);
        check("nf_issue_fwd_a", fwd_a, 0);
        // rs2 hazard via MEM-WB; unused source and r0 never stall
        idle();
        fd_rs2 = 6; fd_uses_rs2 = 1'b1; mw_write_reg = 6; mw_reg_wrenable = 1'b1;
        settle();
        check("nf_rs2_stall", ex_bubble, 1);
        fd_uses_rs2 = 1'b0;
        settle();
        check("nf_unused_no_stall", ex_bubble, 0);
        fd_rs2 = 0; fd_uses_rs2 = 1'b1; mw_write_reg = 0;
        settle();
        check("nf_r0_no_stall", ex_bubble, 0);
        step(); exp_pc++;
        check("nf_after_pc", pc, exp_pc);
        check("nf_fwd_b", fwd_b, 0);
`endif

        // halt drain from pc=9
        idle();
        ex_jump = 1'b1; ex_jump_pc = 9;
        step();
        check("halt_setup_pc", pc, 9);
        idle();
        fd_halt = 1'b1;
        settle();
        check("halt_hold", fd_hold, 1);
        check("halt_bubble", ex_bubble, 1);
        step();
        check("drain1_state", dbg_state, ST_DRAIN);
        check("drain1_halted", halted, 0);
        check("drain1_pc", pc, 9);
        fd_halt = 1'b0; ex_jump = 1'b1; ex_jump_pc = 3;
        settle();
        check("drain_hold", fd_hold, 1);
        check("drain_bubble", ex_bubble, 1);
        step();
        check("drain2_halted", halted, 0);
        check("drain2_pc", pc, 9);
        step();
        check("halted_rise", halted, 1);
        check("halted_state", dbg_state, ST_HALTED);
        check("halted_pc", pc, 9);
        idle();
        step();
        check("halted_stays", halted, 1);
        check("halted_bubble", ex_bubble, 1);
        check("halted_hold", fd_hold, 1);
        reset = 1'b1;
        settle();
        check("halt_reset_hold", fd_hold, 0);
        check("halt_reset_bubble", ex_bubble, 1);
        step();
        check("halt_reset_pc", pc, 0);
        check("halt_reset_halted", halted, 0);
        check("halt_reset_state", dbg_state, ST_RUN);
        reset = 1'b0;
        step();
        check("restart_pc", pc, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
